// File: rtl/seg_reader_if.sv
// Bundle between the seven-segment reader and its byte consumer.
// master: reader side; slave: pattern source and consumer side.
interface seg_reader_if;
    logic [13:0] seg_in;
    logic        out_ready;
    logic [7:0]  hex_out;
    logic        out_valid;
    logic        blank;
    logic        err;
    logic        overflow;
    logic [7:0]  err_cnt;

    modport master (
        input  seg_in, out_ready,
        output hex_out, out_valid, blank, err, overflow, err_cnt
    );

    modport slave (
        output seg_in, out_ready,
        input  hex_out, out_valid, blank, err, overflow, err_cnt
    );
endinterface

// File: rtl/seg_reader.sv
// Debounces a two-digit active-low seven-segment pattern and
// delivers the decoded byte through a single-entry hold register.
module seg_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         reset,
    seg_reader_if.master bus
);
    typedef enum logic {EMPTY, FULL} state_t;

    localparam logic [7:0] SMAX = 8'(STABLE_CYCLES);

    state_t      state, nxt_state;
    logic [13:0] samp;
    logic [7:0]  cnt, nxt_cnt;
    logic        same, settle;
    logic [4:0]  dh, dl;
    logic        is_blank, dec_ok, bad;
    logic        load, drop;
    logic [7:0]  hex_q, err_cnt_q;
    logic        blank_q, err_q, ovf_q;

    // bit 4 flags a legal digit, bits 3:0 carry its value
    function automatic logic [4:0] dec7(input logic [6:0] s);
        case (s)
            7'b1000000: dec7 = 5'h10;
            7'b1111001: dec7 = 5'h11;
            7'b0100100: dec7 = 5'h12;
            7'b0110000: dec7 = 5'h13;
            7'b0011001: dec7 = 5'h14;
            7'b0010010: dec7 = 5'h15;
            7'b0000010: dec7 = 5'h16;
            7'b1111000: dec7 = 5'h17;
            7'b0000000: dec7 = 5'h18;
            7'b0010000: dec7 = 5'h19;
            7'b0001000: dec7 = 5'h1A;
            7'b0000011: dec7 = 5'h1B;
            7'b1000110: dec7 = 5'h1C;
            7'b0100001: dec7 = 5'h1D;
            7'b0000110: dec7 = 5'h1E;
            7'b0001110: dec7 = 5'h1F;
            default:    dec7 = 5'h00;
        endcase
    endfunction

    // a zero count means no valid previous sample yet
    always_comb begin
        same    = (cnt != 8'd0) && (bus.seg_in == samp);
        nxt_cnt = 8'd1;
        if (same)
            nxt_cnt = (cnt == SMAX) ? cnt : cnt + 8'd1;
        settle = same && (cnt == SMAX - 8'd1);
    end

    always_comb begin
        dh       = dec7(bus.seg_in[13:7]);
        dl       = dec7(bus.seg_in[6:0]);
        is_blank = (bus.seg_in == 14'h3FFF);
        dec_ok   = settle && dh[4] && dl[4];
        bad      = settle && !is_blank && !(dh[4] && dl[4]);
    end

    always_comb begin
        nxt_state = state;
        load      = 1'b0;
        drop      = 1'b0;
        case (state)
            EMPTY: begin
                if (dec_ok) begin
                    load      = 1'b1;
                    nxt_state = FULL;
                end
            end
            FULL: begin
                if (dec_ok) begin
                    if (bus.out_ready)
                        load = 1'b1;
                    else
                        drop = 1'b1;
                end else if (bus.out_ready) begin
                    nxt_state = EMPTY;
                end
            end
            default: nxt_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            samp      <= 14'h0000;
            cnt       <= 8'd0;
            hex_q     <= 8'h00;
            blank_q   <= 1'b0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state <= nxt_state;
            samp  <= bus.seg_in;
            cnt   <= nxt_cnt;
            err_q <= bad;
            ovf_q <= drop;
            if (load)
                hex_q <= {dh[3:0], dl[3:0]};
            if (settle && is_blank)
                blank_q <= 1'b1;
            else if (dec_ok)
                blank_q <= 1'b0;
            if (bad && err_cnt_q != 8'hFF)
                err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.hex_out   = hex_q;
    assign bus.out_valid = (state == FULL);
    assign bus.blank     = blank_q;
    assign bus.err       = err_q;
    assign bus.overflow  = ovf_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_seg_reader.sv
// Directed bench for seg_reader with a queue of expected bytes.
// Inputs change 1ns after each rising edge; outputs are read there.
module tb_seg_reader;
    localparam int S = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [7:0] exp_q[$];
    logic [7:0] e;

    seg_reader_if bus ();

    seg_reader #(.STABLE_CYCLES(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_byte(input string tag);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=%0h expected=none", tag, bus.hex_out);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 16'(bus.hex_out), 16'(e));
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_hex"},   16'(bus.hex_out),   16'h00);
        chk({tag, "_valid"}, 16'(bus.out_valid), 16'h0);
        chk({tag, "_blank"}, 16'(bus.blank),     16'h0);
        chk({tag, "_err"},   16'(bus.err),       16'h0);
        chk({tag, "_ovf"},   16'(bus.overflow),  16'h0);
        chk({tag, "_ecnt"},  16'(bus.err_cnt),   16'h0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.seg_in    = 14'h3FFF;
        bus.out_ready = 1'b0;
        step(2);
        chk_reset("rst");

        // 0x3A settles on the 4th edge with consumer stalled
        reset      = 1'b0;
        bus.seg_in = 14'h1808;
        step(S - 1);
        chk("early_valid", 16'(bus.out_valid), 16'h0);
        exp_q.push_back(8'h3A);
        step(1);
        chk("set_valid", 16'(bus.out_valid), 16'h1);
        chk_byte("set_hex");
        chk("set_blank", 16'(bus.blank), 16'h0);
        step(3);
        chk("hold_err", 16'(bus.err), 16'h0);
        chk("hold_ovf", 16'(bus.overflow), 16'h0);
        chk("hold_valid", 16'(bus.out_valid), 16'h1);

        bus.out_ready = 1'b1;
        step(1);
        chk("hs_valid", 16'(bus.out_valid), 16'h0);
        chk("hs_hex", 16'(bus.hex_out), 16'h3A);
        step(1);
        chk("idle_ready", 16'(bus.out_valid), 16'h0);
        bus.out_ready = 1'b0;

        // short run then blank
        reset = 1'b1;
        step(1);
        reset      = 1'b0;
        bus.seg_in = 14'h1808;
        step(S - 1);
        bus.seg_in = 14'h3FFF;
        step(S - 1);
        chk("blank_early", 16'(bus.blank), 16'h0);
        step(1);
        chk("blank_set", 16'(bus.blank), 16'h1);
        chk("blank_valid", 16'(bus.out_valid), 16'h0);
        chk("blank_err", 16'(bus.err), 16'h0);

        // one half off is an error
        bus.seg_in = 14'h3FC0;
        step(S);
        chk("bad_err", 16'(bus.err), 16'h1);
        chk("bad_ecnt", 16'(bus.err_cnt), 16'h1);
        chk("bad_valid", 16'(bus.out_valid), 16'h0);
        chk("bad_blank", 16'(bus.blank), 16'h1);
        bus.seg_in = 14'h1808;
        step(1);
        chk("err_pulse", 16'(bus.err), 16'h0);

        // drop then replace
        exp_q.push_back(8'h3A);
        step(S - 1);
        chk_byte("ld_hex");
        chk("ld_blank", 16'(bus.blank), 16'h0);
        bus.seg_in = 14'h0000;
        step(S);
        chk("drop_ovf", 16'(bus.overflow), 16'h1);
        chk("drop_hex", 16'(bus.hex_out), 16'h3A);
        bus.seg_in = 14'h1808;
        step(1);
        chk("ovf_pulse", 16'(bus.overflow), 16'h0);
        bus.seg_in = 14'h0000;
        step(S - 1);
        bus.out_ready = 1'b1;
        exp_q.push_back(8'h88);
        step(1);
        chk_byte("rep_hex");
        chk("rep_ovf", 16'(bus.overflow), 16'h0);
        chk("rep_valid", 16'(bus.out_valid), 16'h1);
        step(1);
        chk("rel_valid", 16'(bus.out_valid), 16'h0);
        chk("rel_hex", 16'(bus.hex_out), 16'h88);
        bus.out_ready = 1'b0;

        // reset discards a held byte
        bus.seg_in = 14'h1808;
        exp_q.push_back(8'h3A);
        step(S);
        chk_byte("pre_rst_hex");
        chk("pre_rst_valid", 16'(bus.out_valid), 16'h1);
        reset = 1'b1;
        step(1);
        chk_reset("mid_rst");
        reset = 1'b0;

        // saturating error counter
        for (int i = 0; i < 256; i++) begin
            bus.seg_in = i[0] ? 14'h007F : 14'h3FC0;
            step(S);
            if (i == 253)
                chk("ecnt_254", 16'(bus.err_cnt), 16'd254);
            if (i == 254)
                chk("ecnt_255", 16'(bus.err_cnt), 16'd255);
        end
        chk("ecnt_sat", 16'(bus.err_cnt), 16'd255);
        chk("sat_err", 16'(bus.err), 16'h1);
        chk("sat_valid", 16'(bus.out_valid), 16'h0);
        chk("sb_empty", 16'(exp_q.size()), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_reader.md
SEG_READER -- requirements
Module: seg_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, SHALL set the consecutive identical samples needed to accept a pattern; legal range 2..255.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-004 seg_in  input  14  SHALL carry the active-low two-digit seven-segment pattern: [13:7] high digit, [6:0] low digit, bit order g..a.
REQ-005 out_ready  input  1  SHALL be the consumer's acceptance of the held byte.
REQ-006 hex_out  output  8  SHALL carry the decoded byte: [7:4] high digit, [3:0] low digit.
REQ-007 out_valid  output  1  SHALL be high while hex_out holds an undelivered byte.
REQ-008 blank  output  1  SHALL be a level that is high while the last accepted pattern was the all-off display.
REQ-009 err  output  1  SHALL be a one-cycle pulse flagging an accepted pattern that does not decode.
REQ-010 overflow  output  1  SHALL be a one-cycle pulse flagging a decoded byte dropped because the output was still held.
REQ-011 err_cnt  output  8  SHALL count err pulses, saturating at 255.

Function
REQ-012 Digit table (7-bit, active-low) SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-013 Block SHALL register seg_in every cycle and keep a stability count of consecutive edges with an identical sample, saturating at STABLE_CYCLES.
REQ-014 Any sample differing from the previous one SHALL restart the count at 1.
REQ-015 A settle event SHALL fire exactly once per stable run, on the edge where the count first reaches STABLE_CYCLES; nothing further fires until seg_in changes.
REQ-016 Settle, seg_in = 14'h3FFF: blank SHALL go 1; no data, no err.
REQ-017 Settle, both halves in table: decoded byte SHALL be delivered per REQ-019..021; blank SHALL go 0.
REQ-018 Settle, any other pattern, including one half all-off: err SHALL pulse 1 cycle; err_cnt SHALL increment unless already 255; blank and hex_out SHALL stay unchanged.
REQ-019 Settle with out_valid=0: hex_out SHALL load and out_valid SHALL rise, visible after the settle edge.
REQ-020 Settle with out_valid=1 and out_ready=1 on the same edge: new byte SHALL replace the old; out_valid SHALL stay 1; no overflow.
REQ-021 Settle with out_valid=1 and out_ready=0: new byte SHALL be dropped; hex_out SHALL stay unchanged; overflow SHALL pulse 1 cycle.
REQ-022 out_valid=1 and out_ready=1 with no settle event SHALL clear out_valid on that edge; hex_out SHALL retain its value.
REQ-023 out_ready while out_valid=0 SHALL have no effect.
REQ-024 Latency: for a pattern sampled on edges k..k+STABLE_CYCLES-1, the outputs SHALL update after edge k+STABLE_CYCLES-1.
REQ-025 Control SHALL be a two-state machine. EMPTY goes to FULL on a delivered byte. FULL goes to EMPTY on a handshake with no new byte. FULL stays FULL on replace or drop.

Reset
REQ-026 While reset=1 at an edge: hex_out=8'h00, out_valid=0, blank=0, err=0, overflow=0, err_cnt=0, stability count=0, state EMPTY.
REQ-027 Reset mid-operation SHALL discard any held byte and partial stable run.
REQ-028 The first edge after reset SHALL count as sample 1.

Verification
REQ-029 seg_in=14'h1808 held 4 edges, out_ready=0 -> after 4th edge hex_out=8'h3A, out_valid=1, blank=0; holding longer produces no further event.
REQ-030 seg_in=14'h1808 held 3 edges, then 14'h3FFF held 4 edges -> no out_valid or err; blank=1 after 4th 3FFF edge.
REQ-031 seg_in=14'h3FC0 held 4 edges -> err pulses once; err_cnt=1; out_valid unchanged.
REQ-032 0x3A held with out_ready=0, then 14'h0000 ("88") settles with out_ready=0 -> overflow pulses, hex_out stays 8'h3A; repeat with out_ready=1 on the settle edge -> hex_out=8'h88, no overflow.
REQ-033 out_valid=1 with hex_out=8'h3A, assert reset for 1 edge -> all outputs at reset values; 256 invalid settles then leave err_cnt=255.
